// File: rtl/aes_inv_lane_ctrl.sv
// Multi-lane AES-128 decrypt engine.
// Splits a wide ciphertext word into LANES 128-bit blocks (lane 0 in the most
// significant slice) and decrypts them in parallel on LANES iterative cores
// that share one key. Adds valid/ready streaming, a sticky key register,
// optional CBC chaining across lanes and words, and a done-timeout watchdog.
//
// Ports (aes_inv_lane_ctrl):
//   clk, rst            clock, synchronous active-high reset (also resets cores)
//   key_wr, key         key load, honoured only while idle
//   iv_wr, iv           CBC chain register load, honoured only while idle
//   cbc_en              1 = CBC, 0 = ECB, sampled when a word is accepted
//   in_valid/in_ready   ciphertext handshake, in_data is DATA_W bits
//   out_valid/out_ready plaintext handshake, out_data is DATA_W bits
//   out_err             qualifies out_valid: the cores timed out, data is zero
//   busy                engine is not idle
//
// Ports (aes_inv_cipher_top): single AES-128 inverse cipher core. ld starts a
// block; kld together with ld first expands a new key, otherwise the last
// round key of the previous expansion is reused. done pulses for one cycle
// when text_out is valid; text_out holds until the next ld.

module aes_inv_lane_ctrl #(
    parameter  int LANES   = 4,
    parameter  int TMO_CYC = 64,
    parameter  int TMO_W   = 8,
    localparam int DATA_W  = 128 * LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic [127:0]      key,
    input  logic              iv_wr,
    input  logic [127:0]      iv,
    input  logic              cbc_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_cin, r_out_data;
    logic              r_mode, r_key_pending, r_out_err;
    logic [127:0]      r_key, r_chain;
    logic [LANES-1:0]  r_done_flags, w_core_done, w_flags_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [DATA_W-1:0] w_core_out, w_xor_term, w_plain;
    logic              w_core_ld, w_core_kld, w_all_done, w_tmo_hit;

    assign w_core_ld  = (r_state == S_LOAD);
    assign w_core_kld = w_core_ld & r_key_pending;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_inv_cipher_top u_core (
            .clk      (clk),
            .rst      (rst),
            .kld      (w_core_kld),
            .ld       (w_core_ld),
            .key      (r_key),
            .text_in  (r_cin[DATA_W-1-128*g -: 128]),
            .text_out (w_core_out[DATA_W-1-128*g -: 128]),
            .done     (w_core_done[g])
        );
        // CBC: lane 0 chains from the previous word, later lanes from the
        // ciphertext of the lane before them in the same word.
        if (g == 0) begin : g_first
            assign w_xor_term[DATA_W-1 -: 128] = r_chain;
        end else begin : g_rest
            assign w_xor_term[DATA_W-1-128*g -: 128] = r_cin[DATA_W-1-128*(g-1) -: 128];
        end
    end

    assign w_plain     = r_mode ? (w_core_out ^ w_xor_term) : w_core_out;
    // Include this cycle's done pulses so completion is seen without delay.
    assign w_flags_nxt = r_done_flags | w_core_done;
    assign w_all_done  = &w_flags_nxt;
    assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned,
        // which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_WAIT;
            S_WAIT:  if (w_all_done || w_tmo_hit) w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the captured ciphertext and mode are pure datapath, only read after
    // a fresh capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid) begin
            r_cin  <= in_data;
            r_mode <= cbc_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key         <= '0;
            r_key_pending <= 1'b1;
            r_chain       <= '0;
            r_done_flags  <= '0;
            r_tmo_cnt     <= '0;
            r_out_data    <= '0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Same-cycle key_wr and in_valid: LOAD reads r_key, so the
                    // new key applies to the block being accepted.
                    if (key_wr) begin
                        r_key         <= key;
                        r_key_pending <= 1'b1;
                    end
                    if (iv_wr) r_chain <= iv;
                end
                S_LOAD: begin
                    r_key_pending <= 1'b0;
                    r_done_flags  <= '0;
                    r_tmo_cnt     <= '0;
                end
                S_WAIT: begin
                    r_done_flags <= w_flags_nxt;
                    r_tmo_cnt    <= r_tmo_cnt + TMO_W'(1);
                    if (w_all_done) begin
                        r_out_data <= w_plain;
                        r_out_err  <= 1'b0;
                    end else if (w_tmo_hit) begin
                        // Cores are in an unknown phase: force a fresh key
                        // expansion on the next block.
                        r_out_data    <= '0;
                        r_out_err     <= 1'b1;
                        r_key_pending <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_err <= 1'b0;
                        if (!r_out_err) r_chain <= r_cin[127:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module aes_inv_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         done
);
    typedef enum logic [1:0] {C_IDLE, C_EXP, C_DEC} cstate_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            4'd10: return 8'h36; default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ Rcon
    function automatic logic [31:0] key_mix(input logic [31:0] w, input logic [3:0] r);
        return {sbox(w[23:16]) ^ rcon(r), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Round key r-1 -> round key r.
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ key_mix(k[31:0], r);
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round key r -> round key r-1, so decryption walks the schedule backwards
    // without storing all eleven round keys.
    function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ key_mix(w3, r);
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows then InvSubBytes; byte (row, col) sits at 127-8*(4*col+row).
    function automatic logic [127:0] inv_pre(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    cstate_t      r_cst, w_cst_nxt;
    logic [127:0] r_st, r_rk, r_klast;
    logic [3:0]   r_rnd;   // index of the round key currently held in r_rk
    logic [127:0] w_rk_fwd, w_rk_prev, w_pre;

    assign w_rk_fwd  = key_fwd(r_rk, r_rnd + 4'd1);
    assign w_rk_prev = key_bwd(r_rk, r_rnd);
    assign w_pre     = inv_pre(r_st) ^ w_rk_prev;

    always_ff @(posedge clk) begin
        if (rst) r_cst <= C_IDLE;
        else     r_cst <= w_cst_nxt;
    end

    always_comb begin
        w_cst_nxt = r_cst;
        if (ld) begin
            w_cst_nxt = kld ? C_EXP : C_DEC;
        end else begin
            case (r_cst)
                C_EXP:   if (r_rnd == 4'd9) w_cst_nxt = C_DEC;
                C_DEC:   if (r_rnd == 4'd1) w_cst_nxt = C_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st     <= '0;
            r_rk     <= '0;
            r_klast  <= '0;
            r_rnd    <= '0;
            text_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld) begin
                if (kld) begin
                    r_st  <= text_in;
                    r_rk  <= key;
                    r_rnd <= 4'd0;
                end else begin
                    r_st  <= text_in ^ r_klast;
                    r_rk  <= r_klast;
                    r_rnd <= 4'd10;
                end
            end else begin
                case (r_cst)
                    C_EXP: begin
                        r_rk  <= w_rk_fwd;
                        r_rnd <= r_rnd + 4'd1;
                        if (r_rnd == 4'd9) begin
                            r_klast <= w_rk_fwd;
                            r_st    <= r_st ^ w_rk_fwd;
                        end
                    end
                    C_DEC: begin
                        r_rk  <= w_rk_prev;
                        r_rnd <= r_rnd - 4'd1;
                        if (r_rnd == 4'd1) begin
                            text_out <= w_pre;
                            done     <= 1'b1;
                        end else begin
                            r_st <= inv_mix(w_pre);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_lane_ctrl.sv
module tb_aes_inv_lane_ctrl;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C1 = 128'hf795bd4a52e29ed713d313fa20e98dbc;
    localparam logic [127:0] Z  = 128'h0;
    localparam logic [511:0] W_A     = {C1, C0, C1, C0};
    localparam logic [511:0] W_B     = {C0, C0, C0, C0};
    localparam logic [511:0] ECB_A   = {C0, Z, C0, Z};
    localparam logic [511:0] CBC0_A  = {C0, C1, Z, C1};
    localparam logic [511:0] CBC_B   = {C0, C0, C0, C0};

    logic         clk = 1'b0;
    logic         rst, key_wr, iv_wr, cbc_en;
    logic [127:0] key, iv;
    logic [511:0] in_data;
    logic         in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [511:0] out_data;
    logic         in_valid2, in_ready2, out_valid2, out_ready2, out_err2, busy2;
    logic [511:0] out_data2;

    int n_tests = 0;
    int n_fail  = 0;
    int kld_cnt  = 0;
    int kld2_cnt = 0;
    int base;

    always #5 clk = ~clk;

    aes_inv_lane_ctrl dut (
        .clk(clk), .rst(rst), .key_wr(key_wr), .key(key), .iv_wr(iv_wr), .iv(iv),
        .cbc_en(cbc_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    aes_inv_lane_ctrl #(.TMO_CYC(4)) dut2 (
        .clk(clk), .rst(rst), .key_wr(key_wr), .key(key), .iv_wr(iv_wr), .iv(iv),
        .cbc_en(cbc_en), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_err(out_err2), .busy(busy2)
    );

    always @(posedge clk) begin
        if (dut.w_core_kld)  kld_cnt  <= kld_cnt + 1;
        if (dut2.w_core_kld) kld2_cnt <= kld2_cnt + 1;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [511:0] d, input logic cbc);
        int k = 0;
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        check("send_ready", in_ready, 1);
        in_data = d; cbc_en = cbc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k = 0;
        while (!out_valid && k < 200) begin @(negedge clk); k++; end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic send2(input logic [511:0] d);
        int k = 0;
        while (!in_ready2 && k < 100) begin @(negedge clk); k++; end
        check("send2_ready", in_ready2, 1);
        in_data = d; cbc_en = 1'b0; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
    endtask

    task automatic wait_out2();
        int k = 0;
        while (!out_valid2 && k < 200) begin @(negedge clk); k++; end
        check("out_valid2_seen", out_valid2, 1);
    endtask

    task automatic take2();
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_wr = 1'b0; iv_wr = 1'b0; cbc_en = 1'b0;
        key = '0; iv = '0; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy, 0);
        check("rst_out_err",   out_err, 0);
        check("rst_out_data",  out_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // ECB with key 0
        key_wr = 1'b1; key = '0;
        @(negedge clk);
        key_wr = 1'b0;
        base = kld_cnt;
        send(W_A, 1'b0);
        wait_out();
        check("ecb_data", out_data, ECB_A);
        check("ecb_err",  out_err, 0);
        check("ecb_kld",  kld_cnt - base, 1);

        // Backpressure with a competing in_valid
        in_data = W_B; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid",    out_valid, 1);
            check("bp_data",     out_data, ECB_A);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        take();
        check("hs_in_ready",  in_ready, 1);
        check("hs_out_valid", out_valid, 0);
        check("hs_busy",      busy, 0);

        // CBC, iv 0, then a chained second word
        iv_wr = 1'b1; iv = '0;
        @(negedge clk);
        iv_wr = 1'b0;
        send(W_A, 1'b1);
        wait_out();
        check("cbc1_data", out_data, CBC0_A);
        check("cbc1_err",  out_err, 0);
        take();
        send(W_B, 1'b1);
        wait_out();
        check("cbc2_data", out_data, CBC_B);
        take();

        // key_wr while busy is ignored
        send(W_A, 1'b0);
        check("wait_busy", busy, 1);
        key_wr = 1'b1; key = '1;
        repeat (3) @(negedge clk);
        key_wr = 1'b0; key = '0;
        wait_out();
        check("keybusy_data", out_data, ECB_A);
        take();

        // key_wr in idle: kld only on the next block's LOAD
        key_wr = 1'b1; key = '0;
        @(negedge clk);
        key_wr = 1'b0;
        base = kld_cnt;
        send(W_A, 1'b0);
        wait_out();
        check("keyidle_data", out_data, ECB_A);
        check("keyidle_kld",  kld_cnt - base, 1);
        take();
        send(W_A, 1'b0);
        wait_out();
        check("keyreuse_data", out_data, ECB_A);
        check("keyreuse_kld",  kld_cnt - base, 1);
        take();

        // Timeout on the TMO_CYC=4 instance
        base = kld2_cnt;
        send2(W_A);
        wait_out2();
        check("tmo_err",  out_err2, 1);
        check("tmo_data", out_data2, '0);
        check("tmo_kld",  kld2_cnt - base, 1);
        take2();
        check("tmo_err_clr", out_err2, 0);
        send2(W_A);
        wait_out2();
        check("tmo2_err", out_err2, 1);
        check("tmo2_kld", kld2_cnt - base, 2);
        take2();

        // Reset in WAIT
        send(W_A, 1'b1);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready",  in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy",      busy, 0);
        check("mid_rst_chain",     dut.r_chain, '0);
        rst = 1'b0;
        @(negedge clk);
        send(W_A, 1'b1);
        wait_out();
        check("post_rst_data", out_data, CBC0_A);
        check("post_rst_err",  out_err, 0);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
